// File: rtl/menu_ctrl.sv
// Main menu sequencer: registered hover detection for the Start and Connect
// buttons, press/release click qualification, the two-board connect handshake
// with a bounded wait, and the one-cycle start_game pulse that leaves the menu.
`timescale 1ns/1ps

module menu_ctrl #(
    parameter int unsigned START_X0 = 220,
    parameter int unsigned START_X1 = 419,
    parameter int unsigned START_Y0 = 240,
    parameter int unsigned START_Y1 = 299,
    parameter int unsigned CONN_X0  = 220,
    parameter int unsigned CONN_X1  = 419,
    parameter int unsigned CONN_Y0  = 320,
    parameter int unsigned CONN_Y1  = 379,
    parameter int          TO_W     = 28,
    parameter int unsigned TIMEOUT  = 200_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] mouse_x,
    input  logic [9:0] mouse_y,
    input  logic       MOUSE_LEFT,
    input  logic       receive_connect,
    input  logic       menu_return,
    output logic       mouse_on_start_button,
    output logic       mouse_on_connect_button,
    output logic       send_connect,
    output logic       start_game,
    output logic       two_player,
    output logic       menu_active
);

    // Button index 0 is Start, index 1 is Connect.
    localparam int NB = 2;
    localparam int BTN_START = 0;
    localparam int BTN_CONN  = 1;

    localparam logic [9:0] BOX_X0 [NB] = '{10'(START_X0), 10'(CONN_X0)};
    localparam logic [9:0] BOX_X1 [NB] = '{10'(START_X1), 10'(CONN_X1)};
    localparam logic [9:0] BOX_Y0 [NB] = '{10'(START_Y0), 10'(CONN_Y0)};
    localparam logic [9:0] BOX_Y1 [NB] = '{10'(START_Y1), 10'(CONN_Y1)};

    // Last counter value spent in SENDING; the counter never exceeds all-ones.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_MAX  = '1;

    typedef enum logic [1:0] {
        TGT_NONE  = 2'd0,
        TGT_START = 2'd1,
        TGT_CONN  = 2'd2
    } target_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SENDING   = 3'd1,
        ST_CONNECTED = 3'd2,
        ST_START1    = 3'd3,
        ST_START2    = 3'd4,
        ST_GAME      = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Hover detection
    // ------------------------------------------------------------------
    logic [NB-1:0] inside_box;
    logic [NB-1:0] hover_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_box
            // Inclusive 10-bit unsigned box compare against the raw cursor.
            assign inside_box[gi] = (mouse_x >= BOX_X0[gi]) && (mouse_x <= BOX_X1[gi]) &&
                                    (mouse_y >= BOX_Y0[gi]) && (mouse_y <= BOX_Y1[gi]);
        end
    endgenerate

    // Register the hover flags so the pixel generator sees a clean, one-cycle-late value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hover_reg <= '0;
        end else begin
            hover_reg <= inside_box;
        end
    end

    // ------------------------------------------------------------------
    // Click qualification
    // ------------------------------------------------------------------
    logic    left_reg;
    logic    left_prev_reg;
    target_t target_reg;
    logic    click_start_reg;
    logic    click_conn_reg;
    logic    press;
    logic    release_edge;

    // Edges are taken between the registered button level and its delayed copy.
    assign press        =  left_reg & ~left_prev_reg;
    assign release_edge = ~left_reg &  left_prev_reg;

    // Latch the button under the cursor on press; fire a one-cycle click on
    // release only if the cursor is still over that same button.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            left_reg        <= 1'b0;
            left_prev_reg   <= 1'b0;
            target_reg      <= TGT_NONE;
            click_start_reg <= 1'b0;
            click_conn_reg  <= 1'b0;
        end else begin
            left_reg        <= MOUSE_LEFT;
            left_prev_reg   <= left_reg;
            click_start_reg <= 1'b0;
            click_conn_reg  <= 1'b0;
            if (press) begin
                if (hover_reg[BTN_START]) begin
                    target_reg <= TGT_START;
                end else if (hover_reg[BTN_CONN]) begin
                    target_reg <= TGT_CONN;
                end else begin
                    target_reg <= TGT_NONE;
                end
            end else if (release_edge) begin
                click_start_reg <= (target_reg == TGT_START) && hover_reg[BTN_START];
                click_conn_reg  <= (target_reg == TGT_CONN)  && hover_reg[BTN_CONN];
                target_reg      <= TGT_NONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Menu / handshake state machine
    // ------------------------------------------------------------------
    state_t          state_reg;
    logic [TO_W-1:0] to_cnt_reg;
    logic            send_connect_reg;
    logic            start_game_reg;
    logic            two_player_reg;
    logic            menu_active_reg;

    // Menu sequencing; outputs are registered and updated together with the state
    // so that every output reflects the state it belongs to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            to_cnt_reg       <= '0;
            send_connect_reg <= 1'b0;
            start_game_reg   <= 1'b0;
            two_player_reg   <= 1'b0;
            menu_active_reg  <= 1'b1;
        end else begin
            start_game_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    send_connect_reg <= 1'b0;
                    menu_active_reg  <= 1'b1;
                    if (click_start_reg) begin
                        state_reg       <= ST_START1;
                        two_player_reg  <= 1'b0;
                        start_game_reg  <= 1'b1;
                        menu_active_reg <= 1'b0;
                    end else if (click_conn_reg) begin
                        state_reg        <= ST_SENDING;
                        to_cnt_reg       <= '0;
                        send_connect_reg <= 1'b1;
                    end
                end

                ST_SENDING: begin
                    // A peer answer wins over a cancel click or the timeout.
                    if (receive_connect) begin
                        state_reg        <= ST_CONNECTED;
                        send_connect_reg <= 1'b1;
                    end else if (click_conn_reg || (to_cnt_reg == TO_LAST)) begin
                        state_reg        <= ST_IDLE;
                        send_connect_reg <= 1'b0;
                    end else if (to_cnt_reg != TO_MAX) begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end

                ST_CONNECTED: begin
                    // Link loss wins over a simultaneous Start click.
                    if (!receive_connect) begin
                        state_reg        <= ST_IDLE;
                        send_connect_reg <= 1'b0;
                    end else if (click_start_reg) begin
                        state_reg       <= ST_START2;
                        two_player_reg  <= 1'b1;
                        start_game_reg  <= 1'b1;
                        menu_active_reg <= 1'b0;
                    end else begin
                        send_connect_reg <= 1'b1;
                    end
                end

                ST_START1, ST_START2: begin
                    state_reg        <= ST_GAME;
                    menu_active_reg  <= 1'b0;
                    send_connect_reg <= two_player_reg;
                end

                ST_GAME: begin
                    menu_active_reg <= 1'b0;
                    if (menu_return) begin
                        state_reg        <= ST_IDLE;
                        send_connect_reg <= 1'b0;
                        two_player_reg   <= 1'b0;
                        menu_active_reg  <= 1'b1;
                    end else begin
                        send_connect_reg <= two_player_reg;
                    end
                end

                default: begin
                    state_reg        <= ST_IDLE;
                    send_connect_reg <= 1'b0;
                    two_player_reg   <= 1'b0;
                    menu_active_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign mouse_on_start_button   = hover_reg[BTN_START];
    assign mouse_on_connect_button = hover_reg[BTN_CONN];
    assign send_connect            = send_connect_reg;
    assign start_game              = start_game_reg;
    assign two_player              = two_player_reg;
    assign menu_active             = menu_active_reg;

endmodule

// File: tb/tb_menu_ctrl.sv
// Scoreboard bench for menu_ctrl: stimulus pushes expected output values
// (per absolute cycle) and expected start_game pulses into queues; a negedge
// monitor pops and compares them independently of the stimulus.
`timescale 1ns/1ps

module tb_menu_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] mouse_x;
    logic [9:0] mouse_y;
    logic       mouse_left;
    logic       receive_connect;
    logic       menu_return;
    logic       mouse_on_start_button;
    logic       mouse_on_connect_button;
    logic       send_connect;
    logic       start_game;
    logic       two_player;
    logic       menu_active;

    always #5 clk = ~clk;

    menu_ctrl #(.TIMEOUT(100)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .mouse_x                 (mouse_x),
        .mouse_y                 (mouse_y),
        .MOUSE_LEFT              (mouse_left),
        .receive_connect         (receive_connect),
        .menu_return             (menu_return),
        .mouse_on_start_button   (mouse_on_start_button),
        .mouse_on_connect_button (mouse_on_connect_button),
        .send_connect            (send_connect),
        .start_game              (start_game),
        .two_player              (two_player),
        .menu_active             (menu_active)
    );

    localparam int S_SH = 0;
    localparam int S_CH = 1;
    localparam int S_SC = 2;
    localparam int S_TP = 3;
    localparam int S_MA = 4;
    localparam int S_SG = 5;

    typedef struct {
        int    cyc;
        int    sig;
        logic  val;
        string name;
    } exp_t;

    typedef struct {
        int   cyc;
        logic tp;
    } start_t;

    exp_t   exp_q[$];
    start_t start_q[$];
    int     n_vec = 0;
    int     n_bad = 0;
    int     cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic sig_val(int s);
        case (s)
            S_SH:    return mouse_on_start_button;
            S_CH:    return mouse_on_connect_button;
            S_SC:    return send_connect;
            S_TP:    return two_player;
            S_MA:    return menu_active;
            default: return start_game;
        endcase
    endfunction

    function automatic void expect_at(int c, int s, logic v, string nm);
        exp_t e;
        e.cyc  = c;
        e.sig  = s;
        e.val  = v;
        e.name = nm;
        exp_q.push_back(e);
    endfunction

    function automatic void expect_start(int c, logic tp);
        start_t e;
        e.cyc = c;
        e.tp  = tp;
        start_q.push_back(e);
    endfunction

    // Monitor: compare every expectation due this cycle, and match every start_game pulse.
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
                n_vec++;
                if (sig_val(exp_q[i].sig) !== exp_q[i].val) begin
                    n_bad++;
                    $display("FAIL %s cyc %0d: got %0b expected %0b",
                             exp_q[i].name, cyc, sig_val(exp_q[i].sig), exp_q[i].val);
                end
                exp_q.delete(i);
            end
        end
        if (start_game === 1'b1) begin
            n_vec++;
            if (start_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_start_game cyc %0d: got pulse expected none", cyc);
            end else begin
                start_t e;
                e = start_q.pop_front();
                if (e.cyc != cyc || two_player !== e.tp) begin
                    n_bad++;
                    $display("FAIL start_game_pulse: got cyc %0d two_player %0b expected cyc %0d two_player %0b",
                             cyc, two_player, e.cyc, e.tp);
                end
            end
        end
    end

    task automatic tick(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_mouse(int x, int y);
        mouse_x = 10'(x);
        mouse_y = 10'(y);
    endtask

    // Press for 3 cycles, then release; rel is the cycle at which the release is driven.
    task automatic do_click(output int rel);
        mouse_left = 1'b1;
        tick(3);
        mouse_left = 1'b0;
        rel = cyc;
    endtask

    int bx  [10] = '{219, 220, 419, 420, 300, 300, 300, 300, 300, 300};
    int by  [10] = '{260, 240, 299, 299, 300, 239, 320, 379, 380, 319};
    int bsh [10] = '{0,   1,   1,   0,   0,   0,   0,   0,   0,   0};
    int bch [10] = '{0,   0,   0,   0,   0,   0,   1,   1,   0,   0};

    initial begin
        int c;
        int rel;
        int rel2;
        int m;
        int g;

        rst_n           = 1'b0;
        mouse_x         = '0;
        mouse_y         = '0;
        mouse_left      = 1'b0;
        receive_connect = 1'b0;
        menu_return     = 1'b0;

        // Reset state
        expect_at(2, S_SH, 1'b0, "rst_hover_start");
        expect_at(2, S_CH, 1'b0, "rst_hover_conn");
        expect_at(2, S_SC, 1'b0, "rst_send_connect");
        expect_at(2, S_TP, 1'b0, "rst_two_player");
        expect_at(2, S_MA, 1'b1, "rst_menu_active");
        expect_at(2, S_SG, 1'b0, "rst_start_game");
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Hover box edges, one cycle latency
        for (int i = 0; i < 10; i++) begin
            set_mouse(bx[i], by[i]);
            c = cyc;
            expect_at(c + 1, S_SH, bsh[i] != 0, "edge_hover_start");
            expect_at(c + 1, S_CH, bch[i] != 0, "edge_hover_conn");
            tick(1);
        end

        // 1: single-player Start click
        set_mouse(300, 260);
        c = cyc;
        expect_at(c,     S_SH, 1'b0, "t1_hover_before");
        expect_at(c + 1, S_SH, 1'b1, "t1_hover_after");
        tick(3);
        do_click(rel);
        expect_start(rel + 3, 1'b0);
        expect_at(rel + 2, S_MA, 1'b1, "t1_menu_active_pre");
        expect_at(rel + 3, S_MA, 1'b0, "t1_menu_active_start");
        expect_at(rel + 3, S_TP, 1'b0, "t1_two_player");
        expect_at(rel + 4, S_MA, 1'b0, "t1_menu_active_game");
        expect_at(rel + 4, S_SG, 1'b0, "t1_start_game_drop");
        expect_at(rel + 4, S_SC, 1'b0, "t1_send_connect_game");
        tick(6);
        menu_return = 1'b1;
        m = cyc;
        expect_at(m + 1, S_MA, 1'b1, "t1_return_menu_active");
        tick(1);
        menu_return = 1'b0;
        tick(3);

        // 2: drag from Start to Connect before release cancels the click
        mouse_left = 1'b1;
        tick(3);
        set_mouse(300, 350);
        c = cyc;
        expect_at(c,     S_SH, 1'b1, "t2_hover_start_before");
        expect_at(c + 1, S_SH, 1'b0, "t2_hover_start_after");
        expect_at(c,     S_CH, 1'b0, "t2_hover_conn_before");
        expect_at(c + 1, S_CH, 1'b1, "t2_hover_conn_after");
        tick(3);
        mouse_left = 1'b0;
        rel = cyc;
        expect_at(rel + 3, S_MA, 1'b1, "t2_still_menu");
        expect_at(rel + 3, S_SC, 1'b0, "t2_no_send");
        tick(8);

        // 3: connect handshake then two-player start
        do_click(rel);
        expect_at(rel + 2, S_SC, 1'b0, "t3_send_before");
        expect_at(rel + 3, S_SC, 1'b1, "t3_send_start");
        tick(53);
        receive_connect = 1'b1;
        c = cyc;
        expect_at(c,     S_SC, 1'b1, "t3_send_at_50");
        expect_at(c + 1, S_SC, 1'b1, "t3_send_connected");
        expect_at(c + 3, S_SC, 1'b1, "t3_send_connected_hold");
        tick(4);
        set_mouse(300, 260);
        tick(3);
        do_click(rel2);
        expect_start(rel2 + 3, 1'b1);
        expect_at(rel2 + 3, S_MA, 1'b0, "t3_menu_active_start");
        expect_at(rel2 + 4, S_SC, 1'b1, "t3_send_in_game");
        expect_at(rel2 + 5, S_TP, 1'b1, "t3_two_player_game");
        tick(7);
        menu_return = 1'b1;
        m = cyc;
        expect_at(m + 1, S_SC, 1'b0, "t3_return_send");
        expect_at(m + 1, S_TP, 1'b0, "t3_return_two_player");
        expect_at(m + 1, S_MA, 1'b1, "t3_return_menu_active");
        tick(1);
        menu_return     = 1'b0;
        receive_connect = 1'b0;
        tick(3);

        // 4: timeout after exactly 100 cycles, twice; then cancel by a second click
        set_mouse(300, 350);
        tick(2);
        for (int k = 0; k < 2; k++) begin
            do_click(rel);
            expect_at(rel + 3,   S_SC, 1'b1, "t4_send_rise");
            expect_at(rel + 102, S_SC, 1'b1, "t4_send_last");
            expect_at(rel + 103, S_SC, 1'b0, "t4_send_fall");
            tick(110);
        end
        do_click(rel);
        expect_at(rel + 3, S_SC, 1'b1, "t4_cancel_rise");
        tick(10);
        do_click(rel2);
        expect_at(rel2 + 2, S_SC, 1'b1, "t4_cancel_hold");
        expect_at(rel2 + 3, S_SC, 1'b0, "t4_cancel_fall");
        tick(6);

        // 5: link lost in the same cycle as click_start
        do_click(rel);
        tick(5);
        receive_connect = 1'b1;
        tick(3);
        set_mouse(300, 260);
        tick(3);
        do_click(rel2);
        expect_at(rel2 + 2, S_SC, 1'b1, "t5_send_before");
        expect_at(rel2 + 3, S_SC, 1'b0, "t5_send_after");
        expect_at(rel2 + 3, S_MA, 1'b1, "t5_menu_active");
        expect_at(rel2 + 4, S_MA, 1'b1, "t5_menu_active_hold");
        expect_at(rel2 + 4, S_TP, 1'b0, "t5_two_player");
        tick(2);
        receive_connect = 1'b0;
        tick(6);

        // 6: reset during a two-player game, then a stray menu_return in IDLE
        set_mouse(300, 350);
        tick(2);
        do_click(rel);
        tick(5);
        receive_connect = 1'b1;
        tick(3);
        set_mouse(300, 260);
        tick(3);
        do_click(rel2);
        expect_start(rel2 + 3, 1'b1);
        tick(6);
        g = cyc;
        rst_n = 1'b0;
        expect_at(g,     S_TP, 1'b1, "t6_two_player_game");
        expect_at(g,     S_SC, 1'b1, "t6_send_game");
        expect_at(g + 1, S_SH, 1'b0, "t6_rst_hover_start");
        expect_at(g + 1, S_CH, 1'b0, "t6_rst_hover_conn");
        expect_at(g + 1, S_SC, 1'b0, "t6_rst_send");
        expect_at(g + 1, S_TP, 1'b0, "t6_rst_two_player");
        expect_at(g + 1, S_MA, 1'b1, "t6_rst_menu_active");
        expect_at(g + 1, S_SG, 1'b0, "t6_rst_start_game");
        tick(1);
        rst_n = 1'b1;
        receive_connect = 1'b0;
        tick(3);
        menu_return = 1'b1;
        m = cyc;
        expect_at(m + 1, S_MA, 1'b1, "t6_idle_return_ma");
        expect_at(m + 2, S_MA, 1'b1, "t6_idle_return_ma_hold");
        expect_at(m + 2, S_SC, 1'b0, "t6_idle_return_send");
        expect_at(m + 2, S_TP, 1'b0, "t6_idle_return_tp");
        tick(1);
        menu_return = 1'b0;
        tick(5);

        // Anything still queued was never observed.
        while (start_q.size() > 0) begin
            start_t e;
            e = start_q.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL missing_start_game: got no pulse expected pulse at cyc %0d", e.cyc);
        end
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL %s unchecked: got nothing expected %0b at cyc %0d", e.name, e.val, e.cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
